ofm_store_ctrl: RTL

OFM_STORE_CTRL -- requirements
Module: ofm_store_ctrl

---
 rtl/ofm_store_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ofm_store_ctrl.sv
// OFM store controller: packs 32-bit OFM words into 128-bit groups and writes
// them bank-interleaved into NUM_BANK SRAMs, yielding to same-bank reads.
module ofm_store_ctrl #(
  parameter int NUM_BANK = 16,
  parameter int AW       = 10,
  parameter int MAX_GRP  = 16384
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [14:0]         i_num_grp,
  input  logic                i_vld,
  input  logic [31:0]         i_ofm,
  output logic                o_rdy,
  input  logic                i_rd_req,
  input  logic [3:0]          i_rd_bank,
  input  logic [AW-1:0]       i_rd_addr,
  output logic [NUM_BANK-1:0] o_rd_cs,
  output logic [AW-1:0]       o_rd_addr,
  output logic [NUM_BANK-1:0] o_wr_cs,
  output logic [AW-1:0]       o_wr_addr,
  output logic                o_we,
  output logic [127:0]        o_wdata,
  output logic                o_busy,
  output logic                o_done
);

  localparam int BW = $clog2(NUM_BANK);
  localparam int GW = BW + AW;
  localparam logic [14:0] MAX_GRP_C = 15'(MAX_GRP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    lane;
  logic [95:0]   pack;
  logic [127:0]  pend_data;
  logic          pend_vld;
  logic [GW-1:0] g;
  logic [14:0]   acc_left;
  logic [14:0]   wr_left;
  logic [AW-1:0] last_addr;
  logic [127:0]  last_data;

  logic [14:0]   num_clamped;
  logic          conflict;
  logic          issue;
  logic          accept;
  logic          last_lane;

  assign num_clamped = (i_num_grp > MAX_GRP_C) ? MAX_GRP_C : i_num_grp;

  // A read always wins its bank; the pending group waits until the bank is free.
  assign conflict  = i_rd_req && (i_rd_bank == g[BW-1:0]);
  assign issue     = pend_vld && !conflict;

  // Lane 3 may only be taken if the pending slot is empty or draining this cycle.
  assign o_rdy     = (state == S_RUN) && (acc_left != 15'd0) &&
                     !((lane == 2'd3) && pend_vld && !issue);
  assign accept    = i_vld && o_rdy;
  assign last_lane = accept && (lane == 2'd3);

  assign o_rd_cs   = i_rd_req ? (NUM_BANK'(1) << i_rd_bank) : '0;
  assign o_rd_addr = i_rd_addr;

  assign o_we      = issue;
  assign o_wr_cs   = issue ? (NUM_BANK'(1) << g[BW-1:0]) : '0;
  assign o_wr_addr = issue ? g[GW-1:BW] : last_addr;
  assign o_wdata   = issue ? pend_data : last_data;

  assign o_busy    = (state != S_IDLE);
  assign o_done    = (state == S_DONE);

  // NOTE: pack/pend_data carry no reset; pend_vld qualifies them, so they live in
  // a reset-free block rather than turning rst into a hidden load enable.
  always_ff @(posedge clk) begin
    if (accept) begin
      unique case (lane)
        2'd0:    pack[31:0]  <= i_ofm;
        2'd1:    pack[63:32] <= i_ofm;
        2'd2:    pack[95:64] <= i_ofm;
        default: pend_data   <= {i_ofm, pack};
      endcase
    end
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lane      <= 2'd0;
      pend_vld  <= 1'b0;
      g         <= '0;
      acc_left  <= '0;
      wr_left   <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (issue) begin
        last_addr <= g[GW-1:BW];
        last_data <= pend_data;
        g         <= g + GW'(1);
        wr_left   <= wr_left - 15'd1;
      end

      if (accept) lane <= lane + 2'd1;

      if (last_lane) begin
        pend_vld <= 1'b1;
        acc_left <= acc_left - 15'd1;
      end else if (issue) begin
        pend_vld <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            g        <= '0;
            lane     <= 2'd0;
            pend_vld <= 1'b0;
            acc_left <= num_clamped;
            wr_left  <= num_clamped;
            state    <= (num_clamped == 15'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue && (wr_left == 15'd1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
